// File: rtl/bitty_uart_pkg.sv
// Shared constants, widths and state encoding for the bitty UART memory responder.
// Optional feature macro: BITTY_MEM_ACK_EN (adds the store-acknowledge states).
// No logic; types only.
package bitty_uart_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [7:0] CMD_LOAD  = 8'h00;
    localparam logic [7:0] CMD_STORE = 8'h01;
    localparam logic [7:0] ACK_BYTE  = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DHI,
        ST_DLO,
        ST_TX_HI,
        ST_WAIT_HI,
        ST_TX_LO,
        ST_WAIT_LO
`ifdef BITTY_MEM_ACK_EN
        ,
        ST_TX_ACK,
        ST_WAIT_ACK
`endif
    } state_t;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } op_t;

endpackage

// File: rtl/bitty_mem_array.sv
// 256 x 16 word memory: synchronous write, combinational read.
// Read data available in the same cycle as the address; write lands on the clock edge.
// No backpressure; contents are not reset.
module bitty_mem_array
    import bitty_uart_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Word write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bitty_mem_responder.sv
// Decodes UART LSU frames (load/store) against a local 256x16 memory; replies with load data.
// Load: tx_en two cycles after the address byte; each reply byte waits for tx_done.
// Optional macro BITTY_MEM_ACK_EN: stores are acknowledged with one 0xA5 byte.
module bitty_mem_responder
    import bitty_uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_done,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       err
);

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          hi_q, hi_d;
    logic [DATA_W-1:0]   reply_q, reply_d;
    logic                tx_en_q, tx_en_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                err_q, err_d;

    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    // The only read happens in ADDR, where the address is the byte arriving now.
    bitty_mem_array u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata ({hi_q, rx_data}),
        .raddr (rx_data),
        .rdata (mem_rdata)
    );

    // Next-state, latch and transmit-strobe decode.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        reply_d   = reply_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_LOAD) begin
                        op_d    = OP_LOAD;
                        state_d = ST_ADDR;
                    end else if (rx_data == CMD_STORE) begin
                        op_d    = OP_STORE;
                        state_d = ST_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_done) begin
                    addr_d = rx_data;
                    if (op_q == OP_LOAD) begin
                        reply_d = mem_rdata;
                        state_d = ST_TX_HI;
                    end else begin
                        state_d = ST_DHI;
                    end
                end
            end
            ST_DHI: begin
                if (rx_done) begin
                    hi_d    = rx_data;
                    state_d = ST_DLO;
                end
            end
            ST_DLO: begin
                if (rx_done) begin
                    // Gated by reset so an abort coinciding with the last byte never writes.
                    mem_we  = !reset;
`ifdef BITTY_MEM_ACK_EN
                    state_d = ST_TX_ACK;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_TX_HI: begin
                tx_en_d   = 1'b1;
                tx_data_d = reply_q[DATA_W-1:8];
                state_d   = ST_WAIT_HI;
                if (rx_done) err_d = 1'b1;
            end
            ST_WAIT_HI: begin
                if (tx_done) state_d = ST_TX_LO;
                if (rx_done) err_d = 1'b1;
            end
            ST_TX_LO: begin
                tx_en_d   = 1'b1;
                tx_data_d = reply_q[7:0];
                state_d   = ST_WAIT_LO;
                if (rx_done) err_d = 1'b1;
            end
            ST_WAIT_LO: begin
                if (tx_done) state_d = ST_IDLE;
                if (rx_done) err_d = 1'b1;
            end
`ifdef BITTY_MEM_ACK_EN
            ST_TX_ACK: begin
                tx_en_d   = 1'b1;
                tx_data_d = ACK_BYTE;
                state_d   = ST_WAIT_ACK;
                if (rx_done) err_d = 1'b1;
            end
            ST_WAIT_ACK: begin
                if (tx_done) state_d = ST_IDLE;
                if (rx_done) err_d = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            addr_q    <= '0;
            hi_q      <= '0;
            reply_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            reply_q   <= reply_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_bitty_mem_responder.sv
// Self-checking bench for bitty_mem_responder: directed frames then randomized traffic
// checked against a word-array reference model and a transmit-handshake monitor.
// Build with BITTY_MEM_ACK_EN defined to expect store acknowledges.
module tb_bitty_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [15:0] exp_mem [0:255];
    bit          known   [0:255];
    logic        exp_err;

    // handshake monitor
    int tx_cnt  = 0;
    int tx_viol = 0;
    bit outstanding = 0;

    bitty_mem_responder dut (
        .clk     (clk),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .tx_done (tx_done),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Count tx_en pulses and flag any strobe issued before the previous byte's tx_done.
    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            if (outstanding) tx_viol++;
            outstanding = 1;
            tx_cnt++;
        end
        if (tx_done === 1'b1) outstanding = 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_tx(output logic [7:0] b, output int lat);
        lat = 0;
        while (tx_en !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (tx_en !== 1'b1) check("tx_timeout", 32'd0, 32'd1);
        b = tx_data;
    endtask

    task automatic hold(input int d, input logic [7:0] expb);
        for (int k = 0; k < d; k++) begin
            tick();
            check("hold_tx_en", {31'd0, tx_en}, 32'd0);
            check("hold_tx_data", {24'd0, tx_data}, {24'd0, expb});
        end
    endtask

    task automatic do_load(input logic [7:0] a, input int d);
        logic [7:0]  b;
        int          lat;
        int          c0;
        logic [15:0] expw;
        expw = exp_mem[a];
        c0 = tx_cnt;
        send_byte(8'h00);
        send_byte(a);
        wait_tx(b, lat);
        check("load_hi_latency", lat, 32'd1);
        check("load_hi_data", {24'd0, b}, {24'd0, expw[15:8]});
        hold(d, expw[15:8]);
        pulse_done();
        wait_tx(b, lat);
        check("load_lo_latency", lat, 32'd1);
        check("load_lo_data", {24'd0, b}, {24'd0, expw[7:0]});
        hold(d, expw[7:0]);
        pulse_done();
        check("load_busy_after", {31'd0, busy}, 32'd0);
        check("load_err", {31'd0, err}, {31'd0, exp_err});
        check("load_tx_pulses", tx_cnt - c0, 32'd2);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] w, input int d);
        int c0;
        c0 = tx_cnt;
        send_byte(8'h01);
        send_byte(a);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        exp_mem[a] = w;
        known[a]   = 1;
`ifdef BITTY_MEM_ACK_EN
        begin
            logic [7:0] b;
            int lat;
            wait_tx(b, lat);
            check("ack_latency", lat, 32'd1);
            check("ack_data", {24'd0, b}, 32'hA5);
            check("ack_busy_during", {31'd0, busy}, 32'd1);
            hold(d, 8'hA5);
            check("ack_busy_before_done", {31'd0, busy}, 32'd1);
            pulse_done();
            check("ack_busy_after", {31'd0, busy}, 32'd0);
            check("ack_pulses", tx_cnt - c0, 32'd1);
        end
`else
        check("store_busy_after", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("store_silent", tx_cnt - c0, 32'd0);
`endif
        check("store_err", {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_en"}, {31'd0, tx_en}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        for (int k = 0; k < 3; k++) begin
            tick();
            check_reset_outputs("reset_hold");
        end
        reset   = 1'b0;
        exp_err = 1'b0;
        outstanding = 0;
        tick();
    endtask

    initial begin
        logic [7:0] b;
        int         lat;
        int         c0;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = 16'h0;
            known[i]   = 0;
        end
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        exp_err = 1'b0;
        reset   = 1'b0;
        #2;
        apply_reset();

        // store then load, back-to-back frames
        do_store(8'h3C, 16'hBEEF, 0);
        do_load(8'h3C, 0);

        // slow transmitter: 50 cycles per byte
        do_load(8'h3C, 50);

        // bad command
        send_byte(8'h7F);
        exp_err = 1'b1;
        check("badcmd_err", {31'd0, err}, 32'd1);
        check("badcmd_busy", {31'd0, busy}, 32'd0);
        do_load(8'h3C, 2);

        // rx byte while waiting for the high reply byte
        apply_reset();
        c0 = tx_cnt;
        send_byte(8'h00);
        send_byte(8'h3C);
        wait_tx(b, lat);
        check("rxtx_hi_data", {24'd0, b}, 32'hBE);
        send_byte(8'h55);
        exp_err = 1'b1;
        check("rxtx_err", {31'd0, err}, 32'd1);
        check("rxtx_busy", {31'd0, busy}, 32'd1);
        check("rxtx_hold_data", {24'd0, tx_data}, 32'hBE);
        pulse_done();
        wait_tx(b, lat);
        check("rxtx_lo_data", {24'd0, b}, 32'hEF);
        pulse_done();
        check("rxtx_busy_after", {31'd0, busy}, 32'd0);
        check("rxtx_pulses", tx_cnt - c0, 32'd2);

        // reset in the middle of a store must not write memory
        apply_reset();
        do_store(8'h10, 16'h7777, 0);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h12);
        check("midstore_busy", {31'd0, busy}, 32'd1);
        apply_reset();
        do_load(8'h10, 0);
        do_store(8'h10, 16'h0000, 1);
        do_load(8'h10, 1);

        // store to the top address
        do_store(8'hFF, 16'h0001, 3);
        do_load(8'hFF, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [7:0] a;
            r = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 15));
            if (r == 0) begin
                send_byte(8'($urandom_range(2, 255)));
                exp_err = 1'b1;
                check("rand_badcmd_err", {31'd0, err}, 32'd1);
            end else if (r < 5) begin
                do_store(a, 16'($urandom), $urandom_range(0, 4));
            end else begin
                if (!known[a]) a = 8'h3C;
                do_load(a, $urandom_range(0, 4));
            end
        end

        check("no_early_tx_en", tx_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bitty_mem_responder.md
# bitty_mem_responder

UART-side memory responder for the bitty processor's load/store unit. It receives LSU request frames as UART bytes and decodes them as loads or stores against a local 256 x 16 memory. Load data goes back over UART, and in one configuration stores are acknowledged. It sits on the far end of the serial link from the core's LSU, between a UART receiver/transmitter pair and the word memory.

## Interface
Parameters:
- none (address width 8, data width 16 fixed by the LSU protocol)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state except memory contents
- rx_data  in  8  received byte; valid only in the cycle rx_done is high
- rx_done  in  1  one-cycle strobe: rx_data holds a new byte
- tx_done  in  1  one-cycle strobe: UART transmitter finished the current byte
- tx_en  out  1  one-cycle strobe: start transmitting tx_data
- tx_data  out  8  byte to transmit; held stable from tx_en until the matching tx_done
- busy  out  1  high whenever state is not IDLE
- err  out  1  sticky protocol-error flag; cleared only by reset

## Operation
- Frame format, in bytes, is MSB first:
  - load: 0x00, addr, then the responder replies with data[15:8] followed by data[7:0]
  - store: 0x01, addr, data[15:8], data[7:0]
- State machine states: IDLE, ADDR, DHI, DLO, TX_HI, WAIT_HI, TX_LO, WAIT_LO, plus TX_ACK and WAIT_ACK when configured.
- IDLE, on rx_done:
  - 0x00 → ADDR with op=load
  - 0x01 → ADDR with op=store
  - any other byte → stay in IDLE and set err
- ADDR, on rx_done:
  - latch addr
  - load: capture mem[addr] into a 16-bit reply register, go to TX_HI
  - store: go to DHI
- DHI, on rx_done: latch the high byte, go to DLO.
- DLO, on rx_done: write mem[addr] <= {hi, rx_data} in that cycle, then go to TX_ACK (configured) or IDLE.
- TX_HI: pulse tx_en with tx_data = reply[15:8], go to WAIT_HI. WAIT_HI exits to TX_LO on tx_done.
- TX_LO / WAIT_LO: same as TX_HI / WAIT_HI with reply[7:0]; WAIT_LO exits to IDLE.
- Half-duplex link: an rx_done seen in any TX_* or WAIT_* state drops the byte and sets err. The transmit sequence continues.
- tx_done outside WAIT_* states is ignored.
- A load issued right after a store to the same address returns the new data, because the write completes before the next frame's ADDR byte.
- Memory is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: tx_en=0, tx_data=0x00, busy=0, err=0, state=IDLE, address/data latches cleared.
- Reset mid-frame aborts the frame immediately. A partial store never writes memory.
- Load latency: address rx_done in cycle N → tx_en high in cycle N+2 (N+1 enters TX_HI, the registered strobe appears at N+2 edge), with tx_data=mem[addr][15:8].
- Second tx_en comes 2 cycles after the first tx_done.
- Store write: memory updated at the clock edge of the low-data-byte rx_done.
- tx_en is never high for more than one cycle. tx_en is never asserted again before tx_done for the previous byte.
- Back-to-back frames: a command byte is accepted in the first cycle IDLE is re-entered.

## Configuration
- BITTY_MEM_ACK_EN defined: after each completed store, the responder transmits one byte 0xA5 (TX_ACK/WAIT_ACK), then returns to IDLE. busy stays high until that byte's tx_done.
- Undefined: stores are silent, and DLO returns directly to IDLE. TX_ACK/WAIT_ACK states are not built.

## Structure
- Shared package bitty_uart_pkg:
  - command constants CMD_LOAD=8'h00, CMD_STORE=8'h01, ACK_BYTE=8'hA5
  - state enum typedef
  - ADDR_W=8, DATA_W=16
- Sub-module bitty_mem_array: 256 x 16, synchronous write, combinational read, no reset.
- FSM, latches and TX logic live in bitty_mem_responder.

## Test plan
- Store then load: send 01,3C,BE,EF then 00,3C. Required: tx bytes BE then EF, err=0, busy=0 afterwards.
- Handshake: delay tx_done by 50 cycles. Required: tx_data stays BE the whole time, no second tx_en before tx_done, tx_en pulses exactly twice per load.
- Bad command: send 0x7F. Required: err=1, state stays IDLE. A following 00,3C load still returns BE,EF.
- RX during TX: inject rx_done=0x55 while in WAIT_HI. Required: err=1, and EF is still sent after tx_done.
- Reset mid-store: send 01,10,12 then assert reset. Then run 01,10,00,00 and 00,10. Required: reply 00,00, all outputs were at reset values during reset.
- With BITTY_MEM_ACK_EN: store 01,FF,00,01. Required: one tx byte A5, busy low only after its tx_done. Without the macro: no tx_en at all.
